// File: rtl/serial_sequence_generator_fsm_if.sv
// Handshake and serial-line bundle for serial_sequence_generator_fsm.
// master: the controlling logic, which drives start/pattern_in/repeat_cnt/gap.
// slave : the generator, which drives a/valid/busy/done.
// SEQGEN_ERR_INJECT_EN adds err_inject (master->slave) and err_seen (slave->master).
interface serial_sequence_generator_fsm_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
);
    logic             start;
    logic [WIDTH-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             a;
    logic             valid;
    logic             busy;
    logic             done;
`ifdef SEQGEN_ERR_INJECT_EN
    logic             err_inject;
    logic             err_seen;
`endif

    modport master (
        output start, pattern_in, repeat_cnt, gap,
`ifdef SEQGEN_ERR_INJECT_EN
        output err_inject,
        input  err_seen,
`endif
        input  a, valid, busy, done
    );

    modport slave (
        input  start, pattern_in, repeat_cnt, gap,
`ifdef SEQGEN_ERR_INJECT_EN
        input  err_inject,
        output err_seen,
`endif
        output a, valid, busy, done
    );
endinterface

// File: rtl/serial_sequence_generator_fsm.sv
// Serial sequence generator: sends a WIDTH-bit pattern MSB-first on bus.a,
// repeated repeat_cnt+1 times with gap zero bits between repetitions.
// Ports:
//   clk  - clock, posedge
//   rst  - synchronous active-high reset
//   bus  - serial_sequence_generator_fsm_if.slave
//          (start/pattern_in/repeat_cnt/gap in, a/valid/busy/done out)
// Optional macro SEQGEN_ERR_INJECT_EN: err_inject inverts the bit sent in
// SEND; err_seen is a sticky flag cleared by rst or the next accepted start.
//
// state | meaning
// IDLE  | waiting for start, outputs low
// SEND  | driving pattern bits, valid=1
// GAP   | driving zero gap bits between repetitions
// DONE  | one-cycle done pulse, then IDLE
module serial_sequence_generator_fsm #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic clk,
    input  logic rst,
    serial_sequence_generator_fsm_if.slave bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] pattern_r;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] rep_left;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_r;
`ifdef SEQGEN_ERR_INJECT_EN
    logic             err_seen_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            pattern_r <= '0;
            bit_cnt   <= '0;
            rep_left  <= '0;
            gap_cnt   <= '0;
            gap_r     <= '0;
`ifdef SEQGEN_ERR_INJECT_EN
            err_seen_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg     <= bus.pattern_in;
                        pattern_r <= bus.pattern_in;
                        bit_cnt   <= BW'(WIDTH - 1);
                        rep_left  <= bus.repeat_cnt;
                        gap_r     <= bus.gap;
                        state     <= SEND;
`ifdef SEQGEN_ERR_INJECT_EN
                        err_seen_r <= 1'b0;
`endif
                    end
                end
                SEND: begin
`ifdef SEQGEN_ERR_INJECT_EN
                    if (bus.err_inject) err_seen_r <= 1'b1;
`endif
                    shreg <= shreg << 1;
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - BW'(1);
                    end else if (rep_left == '0) begin
                        state <= DONE;
                    end else if (gap_r == '0) begin
                        // back-to-back repetition without leaving SEND
                        shreg    <= pattern_r;
                        bit_cnt  <= BW'(WIDTH - 1);
                        rep_left <= rep_left - CNT_W'(1);
                    end else begin
                        gap_cnt <= gap_r - GAP_W'(1);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        shreg    <= pattern_r;
                        bit_cnt  <= BW'(WIDTH - 1);
                        rep_left <= rep_left - CNT_W'(1);
                        state    <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.valid = (state == SEND);
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == DONE);
`ifdef SEQGEN_ERR_INJECT_EN
    assign bus.a        = (state == SEND) & (shreg[WIDTH-1] ^ bus.err_inject);
    assign bus.err_seen = err_seen_r;
`else
    assign bus.a        = (state == SEND) & shreg[WIDTH-1];
`endif
endmodule

// File: tb/tb_serial_sequence_generator_fsm.sv
// Self-checking bench for serial_sequence_generator_fsm: table vectors,
// hand-written corner sequences and randomized bursts against a queue model.
module tb_serial_sequence_generator_fsm;
    localparam int WIDTH = 6;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    serial_sequence_generator_fsm_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    serial_sequence_generator_fsm #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  p;
        int          rep;
        int          g;
        int          len;
        logic [31:0] s;
        logic [31:0] v;
    } vec_t;

    vec_t tbl[5];

    // outputs packed as {a, valid, busy, done}
    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {a,valid,busy,done}/flag got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.a, bus.valid, bus.busy, bus.done};
    endfunction

    // Reference model: the burst as a list of per-cycle output vectors,
    // starting the cycle after acceptance, ending with the done and idle cycles.
    task automatic build_exp(input logic [5:0] p, input int rep, input int g,
                             output logic [3:0] q[$]);
        q = {};
        for (int r = 0; r <= rep; r++) begin
            for (int b = WIDTH - 1; b >= 0; b--) q.push_back({p[b], 3'b110});
            if (r < rep) for (int k = 0; k < g; k++) q.push_back(4'b0010);
        end
        q.push_back(4'b0011);
        q.push_back(4'b0000);
    endtask

    task automatic accept(input logic [5:0] p, input int rep, input int g, input bit hold);
        bus.pattern_in = p;
        bus.repeat_cnt = CNT_W'(rep);
        bus.gap        = GAP_W'(g);
        bus.start      = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
    endtask

    // Compare one cycle per queue entry; at index poke_at a new start with
    // different operands is raised for one cycle and must have no effect.
    task automatic run_check(input string nm, input logic [3:0] q[$],
                             input int poke_at, input logic [5:0] poke_pat);
        for (int i = 0; i < q.size(); i++) begin
            check($sformatf("%s[%0d]", nm, i), outs(), q[i]);
            if (i == poke_at) begin
                bus.start      = 1'b1;
                bus.pattern_in = poke_pat;
                bus.repeat_cnt = CNT_W'($urandom);
                bus.gap        = GAP_W'($urandom);
            end
            @(negedge clk);
            if (i == poke_at) bus.start = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] q[$];
        int rep, g, poke;
        logic [5:0] p;

        tbl[0] = '{6'b110011, 0, 0, 6,  32'b110011,               32'b111111};
        tbl[1] = '{6'b110011, 1, 0, 12, 32'b110011110011,         32'hFFF};
        tbl[2] = '{6'b110011, 1, 2, 14, 32'b11001100110011,       32'b11111100111111};
        tbl[3] = '{6'b101101, 2, 1, 20, 32'b10110101011010101101, 32'b11111101111110111111};
        tbl[4] = '{6'b100001, 0, 5, 6,  32'b100001,               32'b111111};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.pattern_in = '0;
        bus.repeat_cnt = '0;
        bus.gap = '0;
`ifdef SEQGEN_ERR_INJECT_EN
        bus.err_inject = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset", outs(), 4'b0000);
`ifdef SEQGEN_ERR_INJECT_EN
        check("reset_err_seen", {3'b000, bus.err_seen}, 4'b0000);
`endif
        rst = 1'b0;
        @(negedge clk);

        // table vectors
        for (int t = 0; t < 5; t++) begin
            q = {};
            for (int i = tbl[t].len - 1; i >= 0; i--)
                q.push_back({tbl[t].s[i], tbl[t].v[i], 2'b10});
            q.push_back(4'b0011);
            q.push_back(4'b0000);
            accept(tbl[t].p, tbl[t].rep, tbl[t].g, 1'b0);
            run_check($sformatf("tbl%0d", t), q, -1, 6'd0);
        end

        // start during SEND with new pattern, then during DONE: both ignored
        build_exp(6'b110011, 0, 0, q);
        accept(6'b110011, 0, 0, 1'b0);
        run_check("busy_send", q, 2, 6'b101010);
        accept(6'b110011, 0, 0, 1'b0);
        run_check("busy_done", q, 6, 6'b101010);

        // held start: next burst's first bit at t+L+2
        build_exp(6'b110011, 1, 2, q);
        accept(6'b110011, 1, 2, 1'b1);
        run_check("held", q, -1, 6'd0);
        check("held_restart", outs(), 4'b1110);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("held_rst", outs(), 4'b0000);
        @(negedge clk);

        // reset mid-burst, then a fresh burst
        accept(6'b110011, 0, 0, 1'b0);
        check("mid_t1", outs(), 4'b1110);
        @(negedge clk);
        check("mid_t2", outs(), 4'b1110);
        @(negedge clk);
        check("mid_t3", outs(), 4'b0110);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_t4", outs(), 4'b0000);
        @(negedge clk);
        check("mid_t5", outs(), 4'b0000);
        build_exp(6'b110011, 0, 0, q);
        accept(6'b110011, 0, 0, 1'b0);
        run_check("mid_fresh", q, -1, 6'd0);

        // rst together with start
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_vs_start", outs(), 4'b0000);
        @(negedge clk);

`ifdef SEQGEN_ERR_INJECT_EN
        accept(6'b110011, 0, 0, 1'b0);
        check("err_b0", outs(), 4'b1110);
        @(negedge clk);
        bus.err_inject = 1'b1;
        #1;
        check("err_b1", outs(), 4'b0110);
        @(negedge clk);
        bus.err_inject = 1'b0;
        check("err_seen_set", {3'b000, bus.err_seen}, 4'b0001);
        check("err_b2", outs(), 4'b0110);
        @(negedge clk);
        check("err_b3", outs(), 4'b0110);
        @(negedge clk);
        check("err_b4", outs(), 4'b1110);
        @(negedge clk);
        check("err_b5", outs(), 4'b1110);
        @(negedge clk);
        check("err_done", outs(), 4'b0011);
        @(negedge clk);
        check("err_seen_hold", {3'b000, bus.err_seen}, 4'b0001);
        build_exp(6'b101010, 0, 0, q);
        accept(6'b101010, 0, 0, 1'b0);
        check("err_seen_clr", {3'b000, bus.err_seen}, 4'b0000);
        run_check("err_after", q, -1, 6'd0);
`endif

        // randomized bursts; first one is the maximum repeat/gap case
        for (int it = 0; it < 40; it++) begin
            p   = 6'($urandom);
            rep = (it == 0) ? 15 : (($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                                                 : $urandom_range(0, 3));
            g   = (it == 0) ? 7 : $urandom_range(0, 7);
            build_exp(p, rep, g, q);
            poke = ($urandom_range(0, 1) == 1) ? $urandom_range(0, q.size() - 2) : -1;
            accept(p, rep, g, 1'b0);
            run_check($sformatf("rnd%0d", it), q, poke, 6'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
